// File: rtl/instr_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_fetch_queue                                                |
// | Brief   : Fetch stage: generates the fetch PC, issues instruction-memory   |
// |           reads and buffers returned instructions in a small FIFO that     |
// |           feeds decode over valid/ready. Redirects flush and restart.      |
// |           Optional macro FETCHQ_BYPASS_EN: forward the memory response     |
// |           straight to decode when the queue is empty (1-cycle latency).    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module instr_fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_data,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [INSTR_W-1:0]         dec_instr,
  output logic [ADDR_W-1:0]          dec_pc,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int                c_AW      = $clog2(DEPTH);
  localparam int                c_PTR_W   = c_AW + 1;
  localparam logic [c_PTR_W:0]  c_DEPTH_W = (c_PTR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_PC_INC  = ADDR_W'(4);

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_inflight_pc;
  logic               r_inflight;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];

  logic [c_PTR_W-1:0] w_count;
  logic [c_PTR_W:0]   w_credit;
  logic               w_empty;
  logic               w_full;
  logic               w_bypass;
  logic               w_enq;
  logic               w_deq;
  logic               w_run;

  // Extra wrap bit in the pointers lets the difference span 0..DEPTH.
  assign w_count  = r_wptr - r_rptr;
  assign w_empty  = (w_count == '0);
  assign w_full   = (w_count == c_PTR_W'(DEPTH));
  // Queued entries plus the outstanding response: never request beyond DEPTH.
  assign w_credit = {1'b0, w_count} + {{c_PTR_W{1'b0}}, r_inflight};
  assign w_run    = reset & ~redirect_valid;

  assign imem_req  = w_run & (w_credit < c_DEPTH_W);
  assign imem_addr = r_fetch_pc;
  assign q_count   = w_count;

`ifdef FETCHQ_BYPASS_EN
  assign w_bypass = w_run & w_empty & r_inflight;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed response consumed by decode never enters the queue.
  assign w_enq     = r_inflight & ~(w_bypass & dec_ready);
  assign w_deq     = ~w_empty & dec_ready;
  assign dec_valid = ~w_empty | w_bypass;

  // Decode outputs: queue head, or the live memory response when bypassing.
  always_comb begin
    dec_instr = '0;
    dec_pc    = '0;
`ifdef FETCHQ_BYPASS_EN
    if (w_bypass) begin
      dec_instr = imem_data;
      dec_pc    = r_inflight_pc;
    end else
`endif
    if (!w_empty) begin
      dec_instr = r_instr_mem[r_rptr[c_AW-1:0]];
      dec_pc    = r_pc_mem[r_rptr[c_AW-1:0]];
    end
  end

  // Fetch PC, in-flight tracking and queue pointers; redirect beats everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc    <= PC_RESET;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_fetch_pc    <= r_fetch_pc + c_PC_INC;
        r_inflight_pc <= r_fetch_pc;
      end
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Queue storage; contents only matter between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_run && w_enq) begin
      r_instr_mem[r_wptr[c_AW-1:0]] <= imem_data;
      r_pc_mem[r_wptr[c_AW-1:0]]    <= r_inflight_pc;
    end
  end

  // The credit check must make a write into a full queue unreachable.
  always_ff @(posedge clk) begin
    if (w_run && w_enq) assert (!w_full || w_deq);
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_instr_fetch_queue                                             |
// | Brief   : Self-checking bench for instr_fetch_queue. The scoreboard holds  |
// |           the program-order stream expected from the latest restart point  |
// |           (reset or redirect); a negedge monitor pops it on every transfer.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          ADDR_W   = 64;
  localparam int          INSTR_W  = 32;
  localparam logic [63:0] PC_RESET = 64'h0;
`ifdef FETCHQ_BYPASS_EN
  localparam logic        BYP = 1'b1;
`else
  localparam logic        BYP = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc;
  logic [$clog2(DEPTH):0] q_count;

  int   checks   = 0;
  int   failures = 0;
  int   n_pop    = 0;
  exp_t exp_q[$];

  instr_fetch_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .PC_RESET(PC_RESET)
  ) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .q_count(q_count)
  );

  always #5 clk = ~clk;

  // 1-cycle registered instruction memory: data word = address >> 2.
  always @(posedge clk) begin
    if (imem_req) imem_data <= imem_addr[33:2];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Expected delivery stream after a restart: start, start+4, ... (wrapping).
  task automatic sb_restart(input logic [ADDR_W-1:0] start);
    logic [ADDR_W-1:0] pc;
    exp_t e;
    exp_q.delete();
    pc = start;
    for (int i = 0; i < 1024; i++) begin
      e.pc    = pc;
      e.instr = pc[33:2];
      exp_q.push_back(e);
      pc = pc + 64'd4;
    end
  endtask

  // Monitor: transfers, hold-stability and occupancy bound, sampled mid-cycle.
  logic               m_hold = 1'b0;
  logic [ADDR_W-1:0]  m_hold_pc;
  logic [INSTR_W-1:0] m_hold_instr;
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      checks++;
      if (q_count > DEPTH) begin
        failures++;
        $display("FAIL q_count_bound actual=%0d required<=%0d", q_count, DEPTH);
      end
    end
    if (m_hold) begin
      chk("hold_valid", {63'd0, dec_valid}, 64'd1);
      chk("hold_pc", dec_pc, m_hold_pc);
      chk("hold_instr", {32'd0, dec_instr}, {32'd0, m_hold_instr});
    end
    if (reset === 1'b1 && !redirect_valid && dec_valid && dec_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_delivery actual_pc=%h required=none", dec_pc);
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        chk("deliver_pc", dec_pc, e.pc);
        chk("deliver_instr", {32'd0, dec_instr}, {32'd0, e.instr});
      end
    end
    m_hold       = (reset === 1'b1) && !redirect_valid && dec_valid && !dec_ready;
    m_hold_pc    = dec_pc;
    m_hold_instr = dec_instr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [ADDR_W-1:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    sb_restart(pc);
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    sb_restart(PC_RESET);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
    chk("rst_dec_valid", {63'd0, dec_valid}, 64'd0);
    chk("rst_q_count", {59'd0, q_count}, 64'd0);
    chk("rst_imem_addr", imem_addr, PC_RESET);
    chk("rst_dec_pc", dec_pc, 64'd0);
    chk("rst_dec_instr", {32'd0, dec_instr}, 64'd0);

    // Release: first request at PC_RESET next cycle, then 2 (or 1) cycle latency.
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rel_imem_req", {63'd0, imem_req}, 64'd1);
    chk("rel_imem_addr", imem_addr, PC_RESET);
    chk("rel_dec_valid0", {63'd0, dec_valid}, 64'd0);
    @(negedge clk);
    chk("latency_dec_valid1", {63'd0, dec_valid}, {63'd0, BYP});
    @(negedge clk);
    chk("latency_dec_valid2", {63'd0, dec_valid}, 64'd1);

    // Streaming: one transfer every cycle.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stream_valid", {63'd0, dec_valid & dec_ready}, 64'd1);
    end

    // Backpressure: queue fills, requests stop, head held.
    step();
    dec_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("bp_q_count", {59'd0, q_count}, DEPTH);
    chk("bp_imem_req", {63'd0, imem_req}, 64'd0);
    chk("bp_head_pc", dec_pc, exp_q[0].pc);

    // Full + single-cycle dequeue: one slot freed, refilled by a new request.
    step();
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    @(negedge clk);
    chk("pulse_q_count_a", {59'd0, q_count}, DEPTH - 1);
    chk("pulse_imem_req_a", {63'd0, imem_req}, 64'd1);
    @(negedge clk);
    chk("pulse_q_count_b", {59'd0, q_count}, DEPTH - 1);
    chk("pulse_imem_req_b", {63'd0, imem_req}, 64'd0);
    @(negedge clk);
    chk("pulse_q_count_c", {59'd0, q_count}, DEPTH);
    step();
    dec_ready = 1'b1;
    repeat (8) step();

    // Redirect with 0x14,0x18,0x1C queued and 0x20 in flight.
    dec_ready = 1'b0;
    do_redirect(64'h14);
    repeat (4) step();
    chk("redir_pre_q_count", {59'd0, q_count}, 64'd3);
    dec_ready = 1'b1;
    do_redirect(64'h400);
    @(negedge clk);
    chk("redir_q_count", {59'd0, q_count}, 64'd0);
    chk("redir_dec_valid", {63'd0, dec_valid}, 64'd0);
    chk("redir_imem_req", {63'd0, imem_req}, 64'd1);
    chk("redir_imem_addr", imem_addr, 64'h400);
    repeat (6) step();

    // PC wraps past 2^64.
    p0 = n_pop;
    do_redirect(64'hFFFF_FFFF_FFFF_FFF8);
    repeat (8) step();
    chk("wrap_delivered_ge4", {63'd0, (n_pop - p0) >= 4}, 64'd1);

    // Random mix of backpressure, redirects and resets.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      dec_ready      = ($urandom_range(0, 99) < 70);
      redirect_valid = 1'b0;
      reset          = 1'b1;
      if (r == 99) begin
        reset = 1'b0;
        sb_restart(PC_RESET);
      end else if (r < 3) begin
        redirect_valid = 1'b1;
        redirect_pc    = {$urandom(), $urandom()} & ~64'd3;
        sb_restart(redirect_pc);
      end
      step();
    end
    redirect_valid = 1'b0;
    reset          = 1'b1;
    dec_ready      = 1'b1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
